// File: rtl/sun2_refresh_arb_if.sv
// Refresh arbiter signal bundle: timer handshake, CPU grant handshake,
// refresh strobes and status.
interface sun2_refresh_arb_if #(
  parameter int DEBT_W = 3
);
  logic              rreq;
  logic              ren_n;
  logic              cpu_req;
  logic              cpu_done;
  logic              cpu_gnt;
  logic              ras_n;
  logic              cas_n;
  logic              ref_busy;
  logic [DEBT_W-1:0] debt;
  logic              ovf;

  modport master (
    output rreq, cpu_req, cpu_done,
    input  ren_n, cpu_gnt, ras_n, cas_n, ref_busy, debt, ovf
  );

  modport slave (
    input  rreq, cpu_req, cpu_done,
    output ren_n, cpu_gnt, ras_n, cas_n, ref_busy, debt, ovf
  );
endinterface

// File: rtl/sun2_refresh_arb.sv
// DRAM refresh scheduler for the 120 CPU board: acknowledges timer requests,
// tracks owed refreshes and shares the array between CPU and CBR refresh.
module sun2_refresh_arb #(
  parameter int RAS_CYCLES = 4,
  parameter int PRE_CYCLES = 3,
  parameter int DEBT_W     = 3,
  parameter int URGENT     = 4
) (
  input logic                CLK,
  input logic                RESET_n,
  sun2_refresh_arb_if.slave  bus
);

  localparam int CNT_MAX = (RAS_CYCLES > PRE_CYCLES) ? RAS_CYCLES : PRE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0]  RAS_LAST = CNT_W'(RAS_CYCLES - 1);
  localparam logic [CNT_W-1:0]  PRE_LAST = CNT_W'(PRE_CYCLES - 1);
  localparam logic [DEBT_W-1:0] DEBT_MAX = {DEBT_W{1'b1}};
  localparam logic [DEBT_W-1:0] URGENT_D = DEBT_W'(URGENT);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CPU     = 3'd1,
    ST_CBR_CAS = 3'd2,
    ST_CBR_RAS = 3'd3,
    ST_PRE     = 3'd4
  } state_t;

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DEBT_W-1:0] debt_r;
  logic              ren_n_r;
  logic              ovf_r;
  logic              cpu_gnt_r;
  logic              ras_n_r;
  logic              cas_n_r;
  logic              ref_busy_r;
  logic              inc_s;
  logic              dec_s;

  // Saturating owed-refresh update; a simultaneous count and retire cancel.
  function automatic logic [DEBT_W-1:0] debt_update(
    input logic [DEBT_W-1:0] cur,
    input logic              inc,
    input logic              dec
  );
    logic [DEBT_W-1:0] nxt;
    if (inc && !dec) begin
      if (cur == DEBT_MAX) begin
        nxt = cur;
      end else begin
        nxt = cur + DEBT_W'(1);
      end
    end else if (dec && !inc) begin
      nxt = cur - DEBT_W'(1);
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

  // Count a timer request only while the acknowledge is idle; retire on PRE entry.
  always_comb begin
    inc_s = bus.rreq & ren_n_r;
    if ((state_r == ST_CBR_RAS) && (cnt_r == RAS_LAST)) begin
      dec_s = 1'b1;
    end else begin
      dec_s = 1'b0;
    end
  end

  // Acknowledge pulse, debt counter and sticky overflow flag.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      ren_n_r <= 1'b1;
      debt_r  <= '0;
      ovf_r   <= 1'b0;
    end else begin
      ren_n_r <= ~inc_s;
      debt_r  <= debt_update(debt_r, inc_s, dec_s);
      if (inc_s && !dec_s && (debt_r == DEBT_MAX)) begin
        ovf_r <= 1'b1;
      end
    end
  end

  // Arbitration FSM; strobes, grant and busy are registered alongside the state.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      cpu_gnt_r  <= 1'b0;
      ras_n_r    <= 1'b1;
      cas_n_r    <= 1'b1;
      ref_busy_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_r <= '0;
          // Urgent debt outranks the CPU; otherwise refresh only fills idle time.
          if (debt_r >= URGENT_D) begin
            state_r    <= ST_CBR_CAS;
            cas_n_r    <= 1'b0;
            ref_busy_r <= 1'b1;
          end else if (bus.cpu_req) begin
            state_r   <= ST_CPU;
            cpu_gnt_r <= 1'b1;
          end else if (debt_r != '0) begin
            state_r    <= ST_CBR_CAS;
            cas_n_r    <= 1'b0;
            ref_busy_r <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CPU: begin
          if (bus.cpu_done) begin
            state_r   <= ST_IDLE;
            cpu_gnt_r <= 1'b0;
          end else begin
            state_r <= ST_CPU;
          end
        end
        ST_CBR_CAS: begin
          state_r <= ST_CBR_RAS;
          ras_n_r <= 1'b0;
          cnt_r   <= '0;
        end
        ST_CBR_RAS: begin
          if (cnt_r == RAS_LAST) begin
            state_r <= ST_PRE;
            ras_n_r <= 1'b1;
            cas_n_r <= 1'b1;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_PRE: begin
          if (cnt_r == PRE_LAST) begin
            state_r    <= ST_IDLE;
            ref_busy_r <= 1'b0;
            cnt_r      <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          cnt_r      <= '0;
          cpu_gnt_r  <= 1'b0;
          ras_n_r    <= 1'b1;
          cas_n_r    <= 1'b1;
          ref_busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ren_n    = ren_n_r;
  assign bus.debt     = debt_r;
  assign bus.ovf      = ovf_r;
  assign bus.cpu_gnt  = cpu_gnt_r;
  assign bus.ras_n    = ras_n_r;
  assign bus.cas_n    = cas_n_r;
  assign bus.ref_busy = ref_busy_r;

endmodule

// File: doc/sun2_refresh_arb.md
Name: sun2_refresh_arb

Overview:
Schedules DRAM refresh on the 120 CPU board and shares the DRAM array between the CPU and refresh. Consumes the timer controller's level refresh request (rreq) and returns the refresh-enable acknowledge (/ren). Keeps a count of owed refreshes ("debt") and runs CAS-before-RAS refresh cycles. Defers refresh to CPU accesses until the debt becomes urgent.

Parameters:
RAS_CYCLES, 4, clocks ras_n is held low during a refresh (min 1)
PRE_CYCLES, 3, clocks of RAS precharge after a refresh (min 1)
DEBT_W, 3, width of the owed-refresh counter
URGENT, 4, debt level at which refresh preempts new CPU grants (1..2^DEBT_W-1)

Ports:
CLK  in  1  board clock (c100), all state on rising edge
RESET_n  in  1  asynchronous active-low reset
rreq  in  1  refresh request from timer PAL, active-high level, held until acknowledged
ren_n  out  1  refresh acknowledge to timer PAL, active-low one-clock pulse
cpu_req  in  1  CPU requests a DRAM cycle, level
cpu_done  in  1  CPU DRAM cycle complete, one-clock pulse while granted
cpu_gnt  out  1  CPU owns DRAM
ras_n  out  1  refresh RAS strobe (wired-OR with CPU RAS externally)
cas_n  out  1  refresh CAS strobe
ref_busy  out  1  refresh sequence in progress (any state other than IDLE/CPU)
debt  out  DEBT_W  current owed-refresh count
ovf  out  1  sticky: a request arrived while debt was saturated

Behaviour:
- Reset (async, RESET_n low):
  - state=IDLE, debt=0, ren_n=1, ras_n=1, cas_n=1, cpu_gnt=0, ovf=0, all sub-counters 0.
  - Reset mid-sequence aborts immediately: strobes go high, debt cleared.
- Acknowledge:
  - If rreq=1 and ren_n=1 at an edge: ren_n<=0 for exactly one clock and the request is counted.
  - rreq seen while ren_n=0 is ignored, because the timer clears rreq one clock after sampling /ren.
  - Result: exactly one count per timer request; minimum spacing is 2 clocks.
- Debt arithmetic, per edge: debt_next = debt + inc - dec.
  - inc = request counted; dec = refresh entering PRE.
  - inc and dec in the same edge leave debt unchanged.
  - If debt = 2^DEBT_W-1 and inc=1 with dec=0: debt holds and ovf<=1. ovf clears only on reset.
- FSM states: IDLE, CPU, CBR_CAS, CBR_RAS, PRE.
  - IDLE priority order:
    - (a) debt>=URGENT -> CBR_CAS
    - (b) cpu_req -> CPU, cpu_gnt<=1
    - (c) debt>0 -> CBR_CAS
    - (d) stay IDLE
  - CPU: cpu_gnt=1. On cpu_done -> IDLE with cpu_gnt<=0. The CPU cycle is never preempted; urgency is evaluated on return to IDLE. cpu_done outside CPU is ignored.
  - CBR_CAS: cas_n=0, ras_n=1 for 1 clock -> CBR_RAS.
  - CBR_RAS: cas_n=0, ras_n=0 for RAS_CYCLES clocks -> PRE.
  - PRE: ras_n=1, cas_n=1 for PRE_CYCLES clocks -> IDLE. Debt decrements on entry.
- Strobes and grant are registered outputs, with no combinational path from inputs.
- cas_n falls one clock before ras_n and rises with it.
- CBR_CAS through PRE totals 1+RAS_CYCLES+PRE_CYCLES clocks (8 with defaults). ref_busy=1 throughout.
- Latency:
  - rreq->ren_n low: 1 clock.
  - IDLE with debt>0 and no cpu_req -> cas_n low: 1 clock.
  - IDLE with cpu_req -> cpu_gnt: 1 clock.
- Back-to-back: PRE->IDLE->CBR_CAS when debt remains. IDLE is occupied one clock between sequences so cpu_req can win when debt<URGENT.

Test Plan:
- Reset: hold RESET_n low mid-CBR_RAS -> ras_n=cas_n=ren_n=1, cpu_gnt=0, debt=0, ovf=0 asynchronously.
- Single refresh: rreq high 2 clocks, no cpu_req:
  - ren_n low exactly 1 clock and debt=1.
  - cas_n low at +1, ras_n low for 4 clocks, PRE 3 clocks.
  - debt=0, ref_busy=0 after 8 clocks.
- CPU deferral: cpu_req held, 3 timer requests arrive -> debt=3, cpu_gnt stays 1 through repeated cycles with no refresh started. A 4th request -> at next cpu_done, IDLE enters CBR_CAS even though cpu_req=1.
- Simultaneous inc/dec: rreq counted on the same edge CBR_RAS->PRE with debt=2 -> debt stays 2.
- Saturation: 8 requests with cpu_req blocking, DEBT_W=3 -> debt=7, ovf=1. Reset clears it. ren_n still pulses for every request.
- Grant timing: cpu_req rises in IDLE with debt=0 -> cpu_gnt at +1. cpu_done pulse -> cpu_gnt low next clock. A stray cpu_done in IDLE has no effect.
